lsu_stage: RTL and testbench
============================

Name: lsu_stage

Overview:
- Memory-access stage directly downstream of the execute unit; consumes the 32-bit execute result as an effective address (loads/stores) or as an ALU result (pass-through).
- Runs a single-outstanding request/acknowledge transaction on the data bus: byte-lane steering for stores, sign/zero extension for loads.
- Presents one registered write-back beat per instruction and stalls upstream via a ready signal while a bus transaction is open.

Parameters:
- XLEN, 32, datapath and address width; only 32 is supported.
- REG_IDX_W, 5, destination register index width.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  stage can accept; a transfer occurs when in_valid && in_ready at a clk edge.
- is_load  in  1  instruction is a load.
- is_store  in  1  instruction is a store; is_load && is_store is illegal and is treated as fault.
- funct3  in  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU; others reserved.
- exec_result  in  32  execute-unit output; effective address for memory ops.
- store_data  in  32  rs2 value.
- rd_idx  in  5  destination register.
- bus_req  out  1  data-bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address, bits [1:0] = 0.
- bus_wdata  out  32  lane-steered store data.
- bus_be  out  4  byte enables.
- bus_ack  in  1  transaction complete, sampled while bus_req = 1.
- bus_err  in  1  error qualifier, valid with bus_ack.
- bus_rdata  in  32  read data, valid with bus_ack.
- wb_valid  out  1  one-cycle write-back pulse.
- wb_rd  out  5  write-back register.
- wb_data  out  32  write-back value.
- fault  out  1  one-cycle fault pulse; wb_valid = 0 in the same cycle.
- fault_addr  out  32  exec_result of the faulting instruction.

Behaviour:
- States: IDLE, BUS.
- in_ready = (state == IDLE), combinational from state only.
- Reset: state IDLE. All outputs 0: bus_req, bus_we, bus_addr, bus_wdata, bus_be, wb_valid, wb_rd, wb_data, fault, fault_addr.
- Pass-through (in IDLE, transfer with !is_load && !is_store):
  - Next cycle: wb_valid = 1, wb_data = exec_result, wb_rd = rd_idx.
  - Stay in IDLE; one instruction per cycle throughput.
- Memory op (in IDLE, transfer with is_load ^ is_store):
  - Latch all inputs and go to BUS.
  - From the next cycle, bus_req = 1 with bus_we/addr/wdata/be registered and held stable until an ack is sampled.
- Store lanes:
  - B: be = 0001 << addr[1:0], wdata = {4{sd[7:0]}}.
  - H: be = 0011 << addr[1:0], wdata = {2{sd[15:0]}}.
  - W: be = 1111, wdata = sd.
- Load: bus_be uses the same lane rule as stores, bus_wdata = 0.
- Load extraction: byte/half selected by addr[1:0]; B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- In BUS on a clk edge with bus_ack = 1:
  - Drop bus_req and return to IDLE.
  - Next cycle, loads with !bus_err: wb_valid = 1, wb_data = extracted value, wb_rd = latched rd.
  - Stores with !bus_err: no wb_valid.
  - bus_err: fault = 1, fault_addr = latched exec_result, no wb_valid.
- Latency:
  - Accept at edge N; bus_req high during cycle N+1.
  - Zero-wait ack in cycle N+1 gives wb_valid in cycle N+2.
  - in_ready returns in cycle N+2; the next transfer can occur at the end of N+2.
- Without an ack, bus_req holds indefinitely; there is no timeout.
- Reserved funct3, or is_load && is_store: no bus request; fault pulse next cycle; stay in IDLE.
- Asynchronous rst asserted mid-transaction: bus_req drops immediately, state goes to IDLE, and the open transaction is abandoned. A bus_ack arriving after reset release while in IDLE is ignored.
- wb_valid and fault never assert together. Both are single-cycle pulses per instruction.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: H/HU with addr[0] = 1, or W with addr[1:0] != 0, issues no bus request; fault pulses the next cycle with fault_addr = exec_result; stay in IDLE.
- Undefined: misaligned accesses are issued with addr[1:0] forced to 00 for lane/extraction purposes (H behaves as H at offset 0 or 2 via addr[1]; W uses be = 1111); no fault.

Test Plan:
- Pass-through: exec_result = 0x0000_1234, rd = 5 -> next cycle wb_valid = 1, wb_rd = 5, wb_data = 0x0000_1234; back-to-back accepts with in_ready held at 1.
- LB sign-extend: addr = 0x1003, bus_rdata = 0x80FF_FF7F, zero-wait ack -> bus_addr = 0x1000, bus_be = 1000, wb_data = 0xFFFF_FF80. LBU at the same address -> wb_data = 0x0000_0080.
- SH: addr = 0x2002, store_data = 0xDEAD_BEEF -> bus_we = 1, bus_be = 1100, bus_wdata = 0xBEEF_BEEF, no wb_valid.
- Wait states: LW at 0x3000, ack after 3 cycles with rdata = 0x1234_5678 -> bus_req/addr stable for all 3 cycles, in_ready = 0 throughout, wb_data = 0x1234_5678 one cycle after ack.
- Bus error: SW at 0x4000, bus_ack = 1 with bus_err = 1 -> fault = 1 for one cycle, fault_addr = 0x4000, wb_valid = 0.
- Reset mid-transaction: rst pulse while bus_req = 1 -> bus_req = 0 immediately, in_ready = 1 after release, a late bus_ack produces no wb_valid. Also with LSU_MISALIGN_TRAP_EN: LW at 0x5002 -> fault, no bus_req.

Source files
------------

// File: rtl/lsu_stage_if.sv
// Execute-to-LSU handshake, data-bus and write-back signal bundle.
// master = environment (execute unit, memory, write-back), slave = lsu_stage.
interface lsu_stage_if #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 is_load;
  logic                 is_store;
  logic [2:0]           funct3;
  logic [XLEN-1:0]      exec_result;
  logic [XLEN-1:0]      store_data;
  logic [REG_IDX_W-1:0] rd_idx;

  logic                 bus_req;
  logic                 bus_we;
  logic [XLEN-1:0]      bus_addr;
  logic [XLEN-1:0]      bus_wdata;
  logic [3:0]           bus_be;
  logic                 bus_ack;
  logic                 bus_err;
  logic [XLEN-1:0]      bus_rdata;

  logic                 wb_valid;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic                 fault;
  logic [XLEN-1:0]      fault_addr;

  modport master (
    output in_valid, is_load, is_store, funct3, exec_result, store_data, rd_idx,
    output bus_ack, bus_err, bus_rdata,
    input  in_ready, bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  wb_valid, wb_rd, wb_data, fault, fault_addr
  );

  modport slave (
    input  in_valid, is_load, is_store, funct3, exec_result, store_data, rd_idx,
    input  bus_ack, bus_err, bus_rdata,
    output in_ready, bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output wb_valid, wb_rd, wb_data, fault, fault_addr
  );
endinterface

// File: rtl/lsu_stage.sv
// Load/store stage: pass-through in 1 cycle, memory ops as one open bus request (ack + 1 cycle to write-back);
// in_ready low while the bus request is open. LSU_MISALIGN_TRAP_EN traps misaligned H/W instead of forcing alignment.
module lsu_stage #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
) (
  input logic        clk,
  input logic        rst,
  lsu_stage_if.slave io
);
  typedef enum logic {IDLE, BUS} state_e;

  state_e               state_q, state_d;
  logic                 we_q, we_d;
  logic [XLEN-1:0]      addr_q, addr_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic [3:0]           be_q, be_d;
  logic [1:0]           off_q, off_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]      eaddr_q, eaddr_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [REG_IDX_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]      wb_data_q, wb_data_d;
  logic                 fault_q, fault_d;
  logic [XLEN-1:0]      fault_addr_q, fault_addr_d;

  logic                 reserved, illegal;
  logic [1:0]           off_w;
  logic [3:0]           be_w;
  logic [XLEN-1:0]      wdata_w;
  logic [XLEN-1:0]      shifted;
  logic [XLEN-1:0]      ld_val;

  // funct3 size field: 00 byte, 01 half, 10 word; bit 2 selects zero-extension.
  assign reserved = (io.funct3[1:0] == 2'b11) || (io.funct3[2] && io.funct3[1]);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = ((io.funct3[1:0] == 2'b01) && io.exec_result[0]) ||
                    ((io.funct3[1:0] == 2'b10) && (io.exec_result[1:0] != 2'b00));
  assign illegal  = (io.is_load && io.is_store) || reserved || misalign;
`else
  assign illegal  = (io.is_load && io.is_store) || reserved;
`endif

  always_comb begin
    off_w   = 2'b00;
    be_w    = 4'b1111;
    wdata_w = io.store_data;
    case (io.funct3[1:0])
      2'b00: begin
        off_w   = io.exec_result[1:0];
        be_w    = 4'b0001 << off_w;
        wdata_w = {4{io.store_data[7:0]}};
      end
      2'b01: begin
        off_w   = {io.exec_result[1], 1'b0};
        be_w    = 4'b0011 << off_w;
        wdata_w = {2{io.store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = io.bus_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_val = shifted;
    case (size_q)
      2'b00:   ld_val = {{(XLEN-8){~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   ld_val = {{(XLEN-16){~uns_q & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    rd_d         = rd_q;
    eaddr_d      = eaddr_q;
    wb_valid_d   = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    fault_d      = 1'b0;
    fault_addr_d = fault_addr_q;

    if (state_q == IDLE) begin
      if (io.in_valid) begin
        if (!io.is_load && !io.is_store) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = io.rd_idx;
          wb_data_d  = io.exec_result;
        end else if (illegal) begin
          fault_d      = 1'b1;
          fault_addr_d = io.exec_result;
        end else begin
          state_d = BUS;
          we_d    = io.is_store;
          addr_d  = {io.exec_result[XLEN-1:2], 2'b00};
          wdata_d = io.is_store ? wdata_w : '0;
          be_d    = be_w;
          off_d   = off_w;
          size_d  = io.funct3[1:0];
          uns_d   = io.funct3[2];
          rd_d    = io.rd_idx;
          eaddr_d = io.exec_result;
        end
      end
    end else if (io.bus_ack) begin
      state_d = IDLE;
      if (io.bus_err) begin
        fault_d      = 1'b1;
        fault_addr_d = eaddr_q;
      end else if (!we_q) begin
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        wb_data_d  = ld_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      rd_q         <= '0;
      eaddr_q      <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      rd_q         <= rd_d;
      eaddr_q      <= eaddr_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // bus_req comes straight from the state register so an async reset drops it at once.
  assign io.in_ready   = (state_q == IDLE);
  assign io.bus_req    = (state_q == BUS);
  assign io.bus_we     = we_q;
  assign io.bus_addr   = addr_q;
  assign io.bus_wdata  = wdata_q;
  assign io.bus_be     = be_q;
  assign io.wb_valid   = wb_valid_q;
  assign io.wb_rd      = wb_rd_q;
  assign io.wb_data    = wb_data_q;
  assign io.fault      = fault_q;
  assign io.fault_addr = fault_addr_q;
endmodule

// File: tb/tb_lsu_stage.sv
// Directed and randomized checks of lsu_stage against a byte-lane reference model.
module tb_lsu_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_stage_if bif ();
  lsu_stage dut (.clk(clk), .rst(rst), .io(bif));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // kind: 0 = pass-through, 1 = bus access, 2 = fault without bus access
  task automatic model(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rdata,
                       output int kind, output logic [3:0] be, output logic [31:0] wdata,
                       output logic [31:0] ldval);
    int sz, off;
    logic [31:0] mask, v;
    be = 4'b0; wdata = 32'b0; ldval = 32'b0;
    case (f3)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      3'b010:         sz = 4;
      default:        sz = 0;
    endcase
    if (!ld && !st) begin
      kind = 0;
    end else if ((ld && st) || sz == 0) begin
      kind = 2;
    end else begin
      kind = 1;
`ifdef LSU_MISALIGN_TRAP_EN
      if ((int'(a[1:0]) % sz) != 0) kind = 2;
`endif
      off = (int'(a[1:0]) / sz) * sz;
      be  = 4'(((1 << sz) - 1) << off);
      for (int i = 0; i < 4; i++)
        wdata[8*i +: 8] = st ? sd[8*(i % sz) +: 8] : 8'h00;
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
      v = (rdata >> (8*off)) & mask;
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
      ldval = v;
    end
  endtask

  task automatic op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] sd, input logic [4:0] rd, input logic [31:0] rdata,
                    input int waits, input bit err);
    int kind;
    logic [3:0] be;
    logic [31:0] wdata, ldval;
    model(ld, st, f3, a, sd, rdata, kind, be, wdata, ldval);
    @(negedge clk);
    bif.in_valid = 1'b1; bif.is_load = ld; bif.is_store = st; bif.funct3 = f3;
    bif.exec_result = a; bif.store_data = sd; bif.rd_idx = rd;
    chk("in_ready_idle", 32'(bif.in_ready), 32'd1);
    @(negedge clk);
    bif.in_valid = 1'b0;
    if (kind == 0) begin
      chk("pt_wb_valid", 32'(bif.wb_valid), 32'd1);
      chk("pt_wb_rd", 32'(bif.wb_rd), 32'(rd));
      chk("pt_wb_data", bif.wb_data, a);
      chk("pt_fault", 32'(bif.fault), 32'd0);
    end else if (kind == 2) begin
      chk("ill_fault", 32'(bif.fault), 32'd1);
      chk("ill_fault_addr", bif.fault_addr, a);
      chk("ill_wb_valid", 32'(bif.wb_valid), 32'd0);
      chk("ill_bus_req", 32'(bif.bus_req), 32'd0);
    end else begin
      chk("mem_bus_req", 32'(bif.bus_req), 32'd1);
      chk("mem_in_ready", 32'(bif.in_ready), 32'd0);
      chk("mem_bus_we", 32'(bif.bus_we), 32'(st));
      chk("mem_bus_addr", bif.bus_addr, {a[31:2], 2'b00});
      chk("mem_bus_be", 32'(bif.bus_be), 32'(be));
      chk("mem_bus_wdata", bif.bus_wdata, wdata);
      for (int w = 0; w < waits; w++) begin
        @(negedge clk);
        chk("wait_bus_req", 32'(bif.bus_req), 32'd1);
        chk("wait_bus_addr", bif.bus_addr, {a[31:2], 2'b00});
        chk("wait_bus_be", 32'(bif.bus_be), 32'(be));
        chk("wait_in_ready", 32'(bif.in_ready), 32'd0);
      end
      bif.bus_ack = 1'b1; bif.bus_err = err; bif.bus_rdata = rdata;
      @(negedge clk);
      bif.bus_ack = 1'b0; bif.bus_err = 1'b0; bif.bus_rdata = $urandom;
      chk("ack_bus_req", 32'(bif.bus_req), 32'd0);
      chk("ack_in_ready", 32'(bif.in_ready), 32'd1);
      chk("ack_wb_valid", 32'(bif.wb_valid), 32'(ld && !err));
      chk("ack_fault", 32'(bif.fault), 32'(err));
      if (ld && !err) begin
        chk("ld_wb_data", bif.wb_data, ldval);
        chk("ld_wb_rd", 32'(bif.wb_rd), 32'(rd));
      end
      if (err) chk("err_fault_addr", bif.fault_addr, a);
    end
    @(negedge clk);
    chk("pulse_wb_valid", 32'(bif.wb_valid), 32'd0);
    chk("pulse_fault", 32'(bif.fault), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bif.in_valid = 1'b0; bif.is_load = 1'b0; bif.is_store = 1'b0; bif.funct3 = 3'b0;
    bif.exec_result = 32'b0; bif.store_data = 32'b0; bif.rd_idx = 5'b0;
    bif.bus_ack = 1'b0; bif.bus_err = 1'b0; bif.bus_rdata = 32'b0;
    #12;
    chk("rst_in_ready", 32'(bif.in_ready), 32'd1);
    chk("rst_bus_req", 32'(bif.bus_req), 32'd0);
    chk("rst_bus_we", 32'(bif.bus_we), 32'd0);
    chk("rst_bus_addr", bif.bus_addr, 32'd0);
    chk("rst_bus_wdata", bif.bus_wdata, 32'd0);
    chk("rst_bus_be", 32'(bif.bus_be), 32'd0);
    chk("rst_wb_valid", 32'(bif.wb_valid), 32'd0);
    chk("rst_wb_rd", 32'(bif.wb_rd), 32'd0);
    chk("rst_wb_data", bif.wb_data, 32'd0);
    chk("rst_fault", 32'(bif.fault), 32'd0);
    chk("rst_fault_addr", bif.fault_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back pass-through with in_ready held high.
    @(negedge clk);
    bif.in_valid = 1'b1; bif.is_load = 1'b0; bif.is_store = 1'b0;
    bif.exec_result = 32'h0000_1234; bif.rd_idx = 5'd5;
    @(negedge clk);
    chk("b2b_wb_valid0", 32'(bif.wb_valid), 32'd1);
    chk("b2b_wb_rd0", 32'(bif.wb_rd), 32'd5);
    chk("b2b_wb_data0", bif.wb_data, 32'h0000_1234);
    chk("b2b_in_ready", 32'(bif.in_ready), 32'd1);
    bif.exec_result = 32'h0000_5678; bif.rd_idx = 5'd6;
    @(negedge clk);
    bif.in_valid = 1'b0;
    chk("b2b_wb_valid1", 32'(bif.wb_valid), 32'd1);
    chk("b2b_wb_rd1", 32'(bif.wb_rd), 32'd6);
    chk("b2b_wb_data1", bif.wb_data, 32'h0000_5678);
    @(negedge clk);
    chk("b2b_wb_done", 32'(bif.wb_valid), 32'd0);

    op(1, 0, 3'b000, 32'h0000_1003, 32'h0, 5'd1, 32'h80FF_FF7F, 0, 0);  // LB
    op(1, 0, 3'b100, 32'h0000_1003, 32'h0, 5'd2, 32'h80FF_FF7F, 0, 0);  // LBU
    op(0, 1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 5'd3, 32'h0, 0, 0);  // SH
    op(1, 0, 3'b010, 32'h0000_3000, 32'h0, 5'd4, 32'h1234_5678, 3, 0);  // LW, 3 waits
    op(0, 1, 3'b010, 32'h0000_4000, 32'h1111_2222, 5'd7, 32'h0, 0, 1); // SW bus error
    op(1, 0, 3'b010, 32'h0000_5002, 32'h0, 5'd8, 32'hCAFE_F00D, 0, 0);  // misaligned LW
    op(1, 0, 3'b101, 32'h0000_6003, 32'h0, 5'd9, 32'h8765_4321, 1, 0);  // misaligned LHU
    op(1, 1, 3'b010, 32'h0000_7000, 32'h0, 5'd10, 32'h0, 0, 0);         // load+store
    op(1, 0, 3'b011, 32'h0000_7004, 32'h0, 5'd11, 32'h0, 0, 0);         // reserved funct3

    // Async reset while a request is open; a late ack must be ignored.
    @(negedge clk);
    bif.in_valid = 1'b1; bif.is_load = 1'b1; bif.is_store = 1'b0; bif.funct3 = 3'b010;
    bif.exec_result = 32'h0000_3000; bif.rd_idx = 5'd12;
    @(negedge clk);
    bif.in_valid = 1'b0;
    chk("rstx_bus_req_before", 32'(bif.bus_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstx_bus_req_now", 32'(bif.bus_req), 32'd0);
    chk("rstx_in_ready", 32'(bif.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    chk("rstx_late_wb_valid", 32'(bif.wb_valid), 32'd0);
    chk("rstx_late_fault", 32'(bif.fault), 32'd0);
    chk("rstx_late_bus_req", 32'(bif.bus_req), 32'd0);

    for (int n = 0; n < 80; n++) begin
      bit ld, st, err;
      int sel;
      sel = int'($urandom_range(0, 9));
      ld  = (sel < 4) || (sel == 9);
      st  = (sel >= 4 && sel < 8) || (sel == 9);
      err = ($urandom_range(0, 7) == 0);
      op(ld, st, 3'($urandom), $urandom, $urandom, 5'($urandom), $urandom,
         int'($urandom_range(0, 3)), err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
